// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and busy scoreboard for the single-write-port register file.
// EXU/LSU write-backs are round-robin arbitrated onto one registered write port.
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int ADDR_COUNT = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hazard,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_err
);

  logic [ADDR_COUNT-1:0] busy_q, busy_d;
  logic                  last_lsu_q, last_lsu_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  wb_err_q, wb_err_d;

  logic                  exu_gnt, lsu_gnt, acc;
  logic [ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;

  assign issue_ready = !busy_q[issue_rd];
  assign hazard      = busy_q[rs1] | busy_q[rs2];
  assign exu_ready   = exu_gnt;
  assign lsu_ready   = lsu_gnt;
  assign rf_wen      = rf_wen_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign wb_err      = wb_err_q;

  // last_lsu_q=1 means LSU was granted last, so EXU wins the next conflict
  always_comb begin
    exu_gnt  = exu_valid && (!lsu_valid || last_lsu_q);
    lsu_gnt  = lsu_valid && (!exu_valid || !last_lsu_q);
    acc      = exu_gnt || lsu_gnt;
    acc_rd   = '0;
    acc_data = '0;
    if (exu_gnt) begin
      acc_rd   = exu_rd;
      acc_data = exu_data;
    end else if (lsu_gnt) begin
      acc_rd   = lsu_rd;
      acc_data = lsu_data;
    end
  end

  always_comb begin
    busy_d     = busy_q;
    last_lsu_d = last_lsu_q;
    wb_err_d   = wb_err_q;
    rf_wen_d   = acc && (acc_rd != '0);
    rf_waddr_d = acc_rd;
    rf_wdata_d = acc_data;
    // Clear at the commit edge; the issue gate guarantees no set of the same index
    if (rf_wen_q)
      busy_d[rf_waddr_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (acc) begin
      last_lsu_d = lsu_gnt;
      if ((acc_rd != '0) && !busy_q[acc_rd])
        wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      last_lsu_q <= 1'b1;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      last_lsu_q <= last_lsu_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: scoreboard, hazard, round-robin arbitration,
// write-back latency, x0 handling, wb_err and mid-stream reset.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1, rs2;
  logic        hazard;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  rf_wb_scheduler #(.ADDR_WIDTH(5), .ADDR_COUNT(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_wb_err", wb_err, 0);
    chk("reset_hazard", hazard, 0);
    chk("reset_issue_ready", issue_ready, 1);

    // Issue rd=5 and observe hazard
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    chk("issue5_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd5; rs2 = 5'd0;
    settle();
    chk("hazard_rs1_5", hazard, 1);
    rs1 = 5'd6;
    settle();
    chk("hazard_rs1_6_rs2_0", hazard, 0);
    rs2 = 5'd5;
    settle();
    chk("hazard_rs2_5", hazard, 1);
    rs1 = 5'd5; rs2 = 5'd0;

    // EXU write-back to 5
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    settle();
    chk("wb5_exu_ready", exu_ready, 1);
    chk("wb5_lsu_ready", lsu_ready, 0);
    tick();
    exu_valid = 1'b0;
    settle();
    chk("wb5_rf_wen", rf_wen, 1);
    chk("wb5_rf_waddr", rf_waddr, 5);
    chk("wb5_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("wb5_hazard_commit_cycle", hazard, 1);
    tick();
    chk("wb5_hazard_after", hazard, 0);
    chk("wb5_rf_wen_idle", rf_wen, 0);
    chk("wb5_wb_err", wb_err, 0);

    // Reset so the pointer favours EXU, then a two-cycle conflict
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    settle();
    chk("rr1_exu_ready", exu_ready, 1);
    chk("rr1_lsu_ready", lsu_ready, 0);
    tick();
    chk("rr1_rf_wen", rf_wen, 1);
    chk("rr1_rf_waddr", rf_waddr, 3);
    chk("rr1_rf_wdata", rf_wdata, 32'h11);
    chk("rr2_exu_ready", exu_ready, 0);
    chk("rr2_lsu_ready", lsu_ready, 1);
    tick();
    chk("rr2_rf_wen", rf_wen, 1);
    chk("rr2_rf_waddr", rf_waddr, 4);
    chk("rr2_rf_wdata", rf_wdata, 32'h22);
    chk("rr3_exu_ready", exu_ready, 1);
    chk("rr3_lsu_ready", lsu_ready, 0);
    chk("rr_wb_err", wb_err, 0);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("rr_idle_rf_wen", rf_wen, 0);

    // WAW gate on rd=7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    settle();
    chk("waw7_blocked", issue_ready, 0);
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
    settle();
    chk("waw7_exu_ready", exu_ready, 1);
    tick();
    exu_valid = 1'b0;
    settle();
    chk("waw7_rf_waddr", rf_waddr, 7);
    chk("waw7_blocked_commit_cycle", issue_ready, 0);
    tick();
    chk("waw7_released", issue_ready, 1);
    issue_valid = 1'b0;

    // LSU write-back to x0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    settle();
    chk("x0_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_rf_wen", rf_wen, 0);
    chk("x0_wb_err", wb_err, 0);

    // Write-back to non-busy register 9
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
    settle();
    chk("err9_exu_ready", exu_ready, 1);
    tick();
    exu_valid = 1'b0;
    chk("err9_rf_wen", rf_wen, 1);
    chk("err9_rf_waddr", rf_waddr, 9);
    chk("err9_rf_wdata", rf_wdata, 32'h99);
    chk("err9_wb_err", wb_err, 1);
    tick(); tick();
    chk("err9_wb_err_sticky", wb_err, 1);

    // Reset on the edge that accepts a write-back to 8
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd8; exu_data = 32'h88;
    rs1 = 5'd8; rs2 = 5'd0;
    settle();
    chk("rst8_hazard_before", hazard, 1);
    chk("rst8_exu_ready", exu_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exu_valid = 1'b0;
    issue_rd = 5'd8;
    settle();
    chk("rst8_rf_wen", rf_wen, 0);
    chk("rst8_hazard", hazard, 0);
    chk("rst8_issue_ready", issue_ready, 1);
    chk("rst8_wb_err", wb_err, 0);
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB0;
    settle();
    chk("rst8_exu_wins", exu_ready, 1);
    chk("rst8_lsu_waits", lsu_ready, 0);
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    chk("rst8_rf_waddr", rf_waddr, 10);
    chk("rst8_rf_wdata", rf_wdata, 32'hA0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
